// File: rtl/multiply_divide_unit_pkg.sv
// multiply_divide_unit_pkg: operation and state encodings for the RV32M multiply/divide unit.
package multiply_divide_unit_pkg;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_t;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_t;
endpackage

// File: rtl/multiply_divide_unit.sv
// multiply_divide_unit: iterative RV32M multiply/divide, one product/quotient bit per cycle,
// sharing a single 2*WIDTH accumulator between shift-add multiply and restoring divide.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  md_op_t           MD_Control,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);
    localparam int CW = $clog2(WIDTH);
    md_state_t          state;
    md_op_t             op;
    logic [CW-1:0]      count;
    logic               last, neg, special;
    logic [WIDTH-1:0]   opnd, spec_val;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic               is_div, na, nb, b_zero, ovf, is_special, neg_in, ge;
    logic [WIDTH-1:0]   a_mag, b_mag, special_res, div_val, div_res, mul_res, final_res;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
    always_comb begin
        is_div      = MD_Control[2];
        na          = MD_Control inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM} && SrcA[WIDTH-1];
        nb          = MD_Control inside {MD_MUL, MD_MULH, MD_DIV, MD_REM} && SrcB[WIDTH-1];
        a_mag       = na ? -SrcA : SrcA;
        b_mag       = nb ? -SrcB : SrcB;
        b_zero      = SrcB == '0;
        ovf         = is_div && !MD_Control[0] && SrcA == {1'b1, {(WIDTH-1){1'b0}}} && &SrcB;
        is_special  = is_div && (b_zero || ovf);
        special_res = b_zero ? (MD_Control[1] ? SrcA : '1) : (MD_Control[1] ? '0 : SrcA);
        neg_in      = is_div && MD_Control[1] ? na : na ^ nb;
        // multiply consumes the multiplier LSB-first from the low half; divide shifts the dividend out of it
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : '0};
        rem_sh      = acc[2*WIDTH-1:WIDTH-1];
        rem_sub     = rem_sh - {1'b0, opnd};
        ge          = rem_sh >= {1'b0, opnd};
        acc_step    = op[2] ? {ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                            : {mul_sum, acc[WIDTH-1:1]};
        prod        = neg ? -acc : acc;
        mul_res     = op == MD_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        div_val     = op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        div_res     = neg ? -div_val : div_val;
        final_res   = special ? spec_val : op[2] ? div_res : mul_res;
    end
    assign Busy = state != MD_IDLE;
    assign Done = state == MD_DONE && !Flush;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= MD_IDLE;
            op       <= MD_MUL;
            count    <= '0;
            last     <= 1'b0;
            neg      <= 1'b0;
            special  <= 1'b0;
            opnd     <= '0;
            spec_val <= '0;
            acc      <= '0;
            Result   <= '0;
        end else if (Flush) begin
            state <= MD_IDLE;
            last  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: if (Start) begin
                    op       <= MD_Control;
                    neg      <= neg_in;
                    special  <= is_special;
                    spec_val <= special_res;
                    opnd     <= is_div ? b_mag : a_mag;
                    acc      <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                    count    <= CW'(WIDTH - 1);
                    last     <= 1'b0;
                    if (EARLY_OUT && is_special) begin
                        state  <= MD_DONE;
                        Result <= special_res;
                    end else begin
                        state <= MD_CALC;
                    end
                end
                // the extra cycle after the final step keeps the wide sign negation off the step adder path
                MD_CALC: if (last) begin
                    state  <= MD_DONE;
                    Result <= final_res;
                    last   <= 1'b0;
                end else begin
                    acc   <= acc_step;
                    count <= count - 1'b1;
                    last  <= count == '0;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiply_divide_unit.sv
// tb_multiply_divide_unit: directed vectors with hand-computed results for the multiply/divide unit,
// checking a fast-exit (EARLY_OUT=1) instance and a full-latency (EARLY_OUT=0) instance side by side.
module tb_multiply_divide_unit;
    import multiply_divide_unit_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    md_op_t      op = MD_MUL;
    logic [31:0] a = '0, b = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] res0, res1;
    int          n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    multiply_divide_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .Start(start), .MD_Control(op), .SrcA(a), .SrcB(b),
        .Flush(flush), .Busy(busy0), .Done(done0), .Result(res0));
    multiply_divide_unit #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_slow (
        .CLK(clk), .RST_N(rst_n), .Start(start), .MD_Control(op), .SrcA(a), .SrcB(b),
        .Flush(flush), .Busy(busy1), .Done(done1), .Result(res1));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    task automatic wait_done(input bit slow, output int lat, output logic [31:0] r, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!(slow ? done1 : done0) && lat < 100) begin
            busy_ok &= slow ? busy1 : busy0;
            @(posedge clk);
            #1 lat++;
        end
        r = slow ? res1 : res0;
    endtask
    task automatic settle;
        int n = 0;
        while ((busy0 || busy1) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("idle_timeout", 32'(n < 100), 32'd1);
    endtask
    task automatic run(input string tag, input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat, input bit slow);
        int lat;
        logic [31:0] r;
        bit bo;
        issue(o, x, y);
        wait_done(slow, lat, r, bo);
        check({tag, "_res"}, r, exp);
        check({tag, "_lat"}, lat, exp_lat);
        settle();
    endtask
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int lat;
        logic [31:0] r, prev;
        bit bo, seen;
        #12;
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_result", res0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        issue(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        wait_done(1'b0, lat, r, bo);
        check("mul_res", r, 32'hFFFF_FFEB);
        check("mul_lat", lat, 33);
        check("mul_busy", bo, 1'b1);
        settle();
        run("mulh",   MD_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run("mulhsu", MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
        run("mulhu",  MD_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33, 1'b0);
        run("div",    MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b0);
        run("rem",    MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
        run("divu",   MD_DIVU,   32'd100,       32'd7,         32'h0000_000E, 33, 1'b0);
        run("remu",   MD_REMU,   32'd100,       32'd7,         32'h0000_0002, 33, 1'b0);
        run("div0",       MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run("remu0",      MD_REMU, 32'd5, 32'd0, 32'h0000_0005, 0, 1'b0);
        run("div_ovf",    MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run("rem_ovf",    MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);
        run("div0_slow",  MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 33, 1'b1);
        run("remu0_slow", MD_REMU, 32'd5, 32'd0, 32'h0000_0005, 33, 1'b1);
        run("ovf_slow",   MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1);
        run("removf_slow", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1);
        run("divu_pre", MD_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33, 1'b0);
        prev = 32'h0000_000E;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", busy0, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen |= done0 | done1;
        end
        check("flush_no_done", seen, 1'b0);
        check("flush_result", res0, prev);
        @(negedge clk);
        op = MD_MUL; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("start_flush_busy", busy0, 1'b0);
        check("start_flush_result", res0, prev);
        issue(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = MD_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, lat, r, bo);
        check("busy_ignore_res", r, 32'hFFFF_FFEB);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("done_ignore_busy", busy0, 1'b0);
        check("done_ignore_result", res0, 32'hFFFF_FFEB);
        settle();
        issue(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy0, 1'b0);
        check("arst_done", done0, 1'b0);
        check("arst_result", res0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        run("mul_after_rst", MD_MUL, 32'd3, 32'd4, 32'h0000_000C, 33, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
